// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared definitions for the PC redirect controller: datapath width, the
// default boot/trap addresses, the sequential fetch increment, the FSM state
// encoding and an alignment helper.
// Optional feature macro used by the controller: PC_REDIRECT_PERF_EN.
package pc_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEF = 32'h0000_0100;
    localparam logic [XLEN-1:0] PC_INC       = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } pc_state_e;

    // Fetch addresses must be word aligned; any set low bit is a bad target.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ctrl_perf.sv
// pc_ctrl_perf
// Two saturating 32-bit performance counters for the PC redirect controller.
// Built only when PC_REDIRECT_PERF_EN is defined.
// Ports:
//   clk            - clock
//   rst            - asynchronous active-low reset
//   redirect_i     - one cycle with an accepted redirect
//   stall_i        - one cycle spent in the STALL state
//   redirect_cnt_o - accepted redirect count (saturating)
//   stall_cnt_o    - stall cycle count (saturating)
module pc_ctrl_perf
    import pc_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic            stall_i,
    output logic [XLEN-1:0] redirect_cnt_o,
    output logic [XLEN-1:0] stall_cnt_o
);

    localparam logic [XLEN-1:0] CNT_ONE = 'd1;
    localparam logic [XLEN-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] redirect_cnt_q, redirect_cnt_d;
    logic [XLEN-1:0] stall_cnt_q,    stall_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        stall_cnt_d    = stall_cnt_q;
        if (redirect_i && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end
        if (stall_i && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign redirect_cnt_o = redirect_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Fetch PC sequencer with branch/jump redirect, hazard stall and misaligned
// target trapping. Build option: PC_REDIRECT_PERF_EN adds saturating redirect
// and stall counters; without it both counter outputs are tied to zero.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   ex_br_valid, ex_br_addr   - taken branch from EX (highest priority)
//   id_jmp_valid, id_jmp_addr - unconditional jump from ID
//   hz_stall                  - hazard-unit stall request
//   if_ready                  - instruction memory accepts the fetch
//   pc_o, pc_valid_o          - fetch address and request valid
//   flush_if_o, flush_id_o    - kill IF/ID and ID/EX instructions
//   misalign_o, mtval_o       - misaligned-target pulse and captured address
//   redirect_cnt_o, stall_cnt_o - performance counters
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_br_valid,
    input  logic [XLEN-1:0] ex_br_addr,
    input  logic            id_jmp_valid,
    input  logic [XLEN-1:0] id_jmp_addr,
    input  logic            hz_stall,
    input  logic            if_ready,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] mtval_o,
    output logic [XLEN-1:0] redirect_cnt_o,
    output logic [XLEN-1:0] stall_cnt_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic            misalign_q, misalign_d;

    logic            redir_req;
    logic            redir_acc;
    logic [XLEN-1:0] redir_tgt;
    logic            tgt_bad;

    // EX branch wins over the ID jump; redirects are dropped while booting.
    assign redir_req = ex_br_valid | id_jmp_valid;
    assign redir_tgt = ex_br_valid ? ex_br_addr : id_jmp_addr;
    assign redir_acc = redir_req && (state_q != ST_BOOT);
    assign tgt_bad   = is_misaligned(redir_tgt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Outside BOOT the stall request alone picks the next state, whether or
    // not a redirect happens in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = ST_RUN;
            ST_RUN,
            ST_STALL: state_d = hz_stall ? ST_STALL : ST_RUN;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_valid_o = (state_q == ST_RUN);
        flush_if_o = redir_req;
        flush_id_o = ex_br_valid;
    end

    // A redirect beats both stall and if_ready=0; a fetch only advances when
    // it was actually presented and accepted.
    always_comb begin
        pc_d       = pc_q;
        mtval_d    = mtval_q;
        misalign_d = 1'b0;
        if (redir_acc) begin
            if (tgt_bad) begin
                pc_d       = TRAP_VEC;
                mtval_d    = redir_tgt;
                misalign_d = 1'b1;
            end else begin
                pc_d = redir_tgt;
            end
        end else if ((state_q == ST_RUN) && if_ready && !hz_stall) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            mtval_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mtval_q    <= mtval_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign mtval_o    = mtval_q;
    assign misalign_o = misalign_q;

`ifdef PC_REDIRECT_PERF_EN
    pc_ctrl_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (redir_acc),
        .stall_i        (state_q == ST_STALL),
        .redirect_cnt_o (redirect_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );
`else
    assign redirect_cnt_o = '0;
    assign stall_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

    typedef struct {
        logic        exv;
        logic [31:0] exa;
        logic        idv;
        logic [31:0] ida;
        logic        hz;
        logic        rdy;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_fif;
        logic        e_fid;
        logic        e_mis;
        logic [31:0] e_mt;
    } vec_t;

`ifdef PC_REDIRECT_PERF_EN
    localparam logic [31:0] EXP_REDIR = 32'd5;
    localparam logic [31:0] EXP_STALL = 32'd7;
`else
    localparam logic [31:0] EXP_REDIR = 32'd0;
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic        clk;
    logic        rst;
    logic        ex_br_valid;
    logic [31:0] ex_br_addr;
    logic        id_jmp_valid;
    logic [31:0] id_jmp_addr;
    logic        hz_stall;
    logic        if_ready;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        misalign_o;
    logic [31:0] mtval_o;
    logic [31:0] redirect_cnt_o;
    logic [31:0] stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    pc_redirect_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ex_br_valid    (ex_br_valid),
        .ex_br_addr     (ex_br_addr),
        .id_jmp_valid   (id_jmp_valid),
        .id_jmp_addr    (id_jmp_addr),
        .hz_stall       (hz_stall),
        .if_ready       (if_ready),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .misalign_o     (misalign_o),
        .mtval_o        (mtval_o),
        .redirect_cnt_o (redirect_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic exv, input logic [31:0] exa,
                                input logic idv, input logic [31:0] ida,
                                input logic hz, input logic rdy,
                                input logic [31:0] pc, input logic vld,
                                input logic fif, input logic fid,
                                input logic mis, input logic [31:0] mt);
        vec_t v;
        v.exv = exv; v.exa = exa; v.idv = idv; v.ida = ida;
        v.hz = hz; v.rdy = rdy; v.e_pc = pc; v.e_vld = vld;
        v.e_fif = fif; v.e_fid = fid; v.e_mis = mis; v.e_mt = mt;
        return v;
    endfunction

    // Drive inputs (called just after a negedge), then check outputs that
    // reflect the registered state plus the combinational flushes.
    task automatic apply(input string tag, input vec_t v);
        ex_br_valid  = v.exv;
        ex_br_addr   = v.exa;
        id_jmp_valid = v.idv;
        id_jmp_addr  = v.ida;
        hz_stall     = v.hz;
        if_ready     = v.rdy;
        #1;
        chk({tag, ".pc"},       pc_o,                v.e_pc);
        chk({tag, ".vld"},      {31'd0, pc_valid_o}, {31'd0, v.e_vld});
        chk({tag, ".flush_if"}, {31'd0, flush_if_o}, {31'd0, v.e_fif});
        chk({tag, ".flush_id"}, {31'd0, flush_id_o}, {31'd0, v.e_fid});
        chk({tag, ".misalign"}, {31'd0, misalign_o}, {31'd0, v.e_mis});
        chk({tag, ".mtval"},    mtval_o,             v.e_mt);
    endtask

    vec_t tbl[19];

    initial begin
        //             exv  exa           idv  ida          hz   rdy  pc            vld  fif  fid  mis  mtval
        tbl[0]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h0,        1'b0,1'b0,1'b0,1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h0,        1'b1,1'b0,1'b0,1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h4,        1'b1,1'b0,1'b0,1'b0, 32'h0);
        tbl[3]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h8,        1'b1,1'b0,1'b0,1'b0, 32'h0);
        tbl[4]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'hC,        1'b1,1'b0,1'b0,1'b0, 32'h0);
        tbl[5]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b1,1'b1, 32'h10,       1'b1,1'b0,1'b0,1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b1,1'b1, 32'h10,       1'b0,1'b0,1'b0,1'b0, 32'h0);
        tbl[7]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b1,1'b1, 32'h10,       1'b0,1'b0,1'b0,1'b0, 32'h0);
        tbl[8]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h10,       1'b0,1'b0,1'b0,1'b0, 32'h0);
        tbl[9]  = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h10,       1'b1,1'b0,1'b0,1'b0, 32'h0);
        tbl[10] = mk(1'b1, 32'h200,      1'b1, 32'h300,    1'b0,1'b1, 32'h14,       1'b1,1'b1,1'b1,1'b0, 32'h0);
        tbl[11] = mk(1'b0, 32'h0,        1'b1, 32'h402,    1'b0,1'b1, 32'h200,      1'b1,1'b1,1'b0,1'b0, 32'h0);
        tbl[12] = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h100,      1'b1,1'b0,1'b0,1'b1, 32'h402);
        tbl[13] = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b0, 32'h104,      1'b1,1'b0,1'b0,1'b0, 32'h402);
        tbl[14] = mk(1'b1, 32'h40,       1'b0, 32'h0,      1'b0,1'b0, 32'h104,      1'b1,1'b1,1'b1,1'b0, 32'h402);
        tbl[15] = mk(1'b0, 32'h0,        1'b1, 32'h80,     1'b1,1'b1, 32'h40,       1'b1,1'b1,1'b0,1'b0, 32'h402);
        tbl[16] = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h80,       1'b0,1'b0,1'b0,1'b0, 32'h402);
        tbl[17] = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h80,       1'b1,1'b0,1'b0,1'b0, 32'h402);
        tbl[18] = mk(1'b0, 32'h0,        1'b0, 32'h0,      1'b0,1'b1, 32'h84,       1'b1,1'b0,1'b0,1'b0, 32'h402);

        rst          = 1'b0;
        ex_br_valid  = 1'b0;
        ex_br_addr   = '0;
        id_jmp_valid = 1'b0;
        id_jmp_addr  = '0;
        hz_stall     = 1'b0;
        if_ready     = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("reset.pc",       pc_o,                32'h0);
        chk("reset.vld",      {31'd0, pc_valid_o}, 32'd0);
        chk("reset.misalign", {31'd0, misalign_o}, 32'd0);
        chk("reset.mtval",    mtval_o,             32'h0);
        chk("reset.redir_cnt", redirect_cnt_o,     32'h0);
        chk("reset.stall_cnt", stall_cnt_o,        32'h0);

        // Release reset at a negedge; the first table row is the BOOT cycle.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i != 0) @(negedge clk);
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Wrap at the top of the address space, then hold with if_ready=0.
        @(negedge clk); apply("wrap0", mk(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1, 32'h88,        1'b1, 1'b1, 1'b1, 1'b0, 32'h402));
        @(negedge clk); apply("wrap1", mk(1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("wrap2", mk(1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("wrap3", mk(1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("wrap4", mk(1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h402));

        // Three more stall cycles so the totals reach 5 redirects / 7 stalls.
        @(negedge clk); apply("stl0", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("stl1", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("stl2", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("stl3", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("stl4", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h402));
        chk("perf.redirect_cnt", redirect_cnt_o, EXP_REDIR);
        chk("perf.stall_cnt",    stall_cnt_o,    EXP_STALL);

        // Reset asserted in the middle of a stall.
        @(negedge clk); apply("abt0", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h402));
        @(negedge clk); apply("abt1", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h402));
        rst = 1'b0;
        #1;
        chk("abort.pc",        pc_o,                32'h0);
        chk("abort.vld",       {31'd0, pc_valid_o}, 32'd0);
        chk("abort.mtval",     mtval_o,             32'h0);
        chk("abort.redir_cnt", redirect_cnt_o,      32'h0);
        chk("abort.stall_cnt", stall_cnt_o,         32'h0);

        // Redirect offered during BOOT: flushes follow inputs, PC ignores it.
        @(negedge clk);
        rst = 1'b1;
        apply("boot0", mk(1'b1, 32'h502, 1'b1, 32'h600, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0));
        @(negedge clk); apply("boot1", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge clk); apply("boot2", mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        chk("boot.redir_cnt", redirect_cnt_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
